// File: rtl/i2c_pkg.sv
// Shared constants for the I2C line front end.
// Defaults for synchroniser depth and glitch-filter persistence, plus the filter counter width.
package i2c_pkg;

    localparam int I2C_SYNC_STAGES_DEF   = 2;
    localparam int I2C_FILTER_CYCLES_DEF = 5;
    localparam int I2C_FILT_CNT_W        = 5;

    typedef logic [I2C_FILT_CNT_W-1:0] filt_cnt_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// One I2C line: synchroniser chain, persistence filter, registered edge pulses.
// Latency SYNC_STAGES+FILTER_CYCLES edges from pin to filt; no backpressure.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
    input  logic clk100,
    input  logic reset,
    input  logic pin,
    output logic filt,
    output logic rise,
    output logic fall,
    output logic settled
);

    localparam filt_cnt_t CNT_LAST = filt_cnt_t'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    filt_cnt_t              cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   mismatch;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pin};
        mismatch = sync_q[SYNC_STAGES-1] ^ filt_q;
        filt_d   = filt_q;
        cnt_d    = '0;
        // Toggle on the FILTER_CYCLES-th consecutive mismatch; any match restarts the count.
        if (mismatch) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = ~filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = filt_d & ~filt_q;
        fall_d = ~filt_d & filt_q;
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            sync_q <= '1;
            cnt_q  <= '0;
            filt_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt    = filt_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign settled = ~mismatch;

endmodule

// File: rtl/i2c_line_filter.sv
// Filtered SCL/SDA with START, repeated START, STOP detection and bus-busy tracking.
// Condition pulses coincide with the qualifying sda_f change; busy follows one cycle later; no backpressure.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES   = I2C_SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = I2C_FILTER_CYCLES_DEF
) (
    input  logic clk100,
    input  logic reset,
    input  logic ck_scl,
    input  logic ck_sda,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic rep_start_det,
    output logic stop_det,
    output logic bus_busy
);

    localparam logic [2:0] HOLD_LAST = 3'(SYNC_STAGES);

    logic       sda_rise, sda_fall;
    logic       scl_settled, sda_settled;
    logic       scl_steady_hi;
    logic [2:0] hold_q, hold_d;
    logic       armed_q, armed_d;
    logic       bus_busy_q, bus_busy_d;

    i2c_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_scl_filt (
        .clk100 (clk100),
        .reset  (reset),
        .pin    (ck_scl),
        .filt   (scl_f),
        .rise   (scl_rise),
        .fall   (scl_fall),
        .settled(scl_settled)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
    ) u_sda_filt (
        .clk100 (clk100),
        .reset  (reset),
        .pin    (ck_sda),
        .filt   (sda_f),
        .rise   (sda_rise),
        .fall   (sda_fall),
        .settled(sda_settled)
    );

    // Conditions stay disarmed until the sync chains hold real samples and both
    // filters agree with them, so the reset-to-first-level move never reads as START/STOP.
    always_comb begin
        hold_d  = hold_q;
        if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 3'd1;
        end
        armed_d = armed_q | ((hold_q == HOLD_LAST) & scl_settled & sda_settled);
    end

    assign scl_steady_hi = scl_f & ~scl_rise & ~scl_fall;
    assign start_det     = armed_q & scl_steady_hi & sda_fall;
    assign stop_det      = armed_q & scl_steady_hi & sda_rise;
    assign rep_start_det = start_det & bus_busy_q;

    always_comb begin
        bus_busy_d = bus_busy_q;
        if (start_det) begin
            bus_busy_d = 1'b1;
        end else if (stop_det) begin
            bus_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk100) begin
        if (!reset) begin
            hold_q     <= '0;
            armed_q    <= 1'b0;
            bus_busy_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            armed_q    <= armed_d;
            bus_busy_q <= bus_busy_d;
        end
    end

    assign bus_busy = bus_busy_q;

endmodule

// File: tb/tb_i2c_line_filter.sv
// Directed and randomized checks of i2c_line_filter against a persistence/condition model.
module tb_i2c_line_filter;
    import i2c_pkg::*;

    localparam int N   = I2C_SYNC_STAGES_DEF;
    localparam int F   = I2C_FILTER_CYCLES_DEF;
    localparam int LAT = N + F - 1;

    logic clk100 = 1'b0;
    logic reset  = 1'b0;
    logic ck_scl = 1'b1;
    logic ck_sda = 1'b1;
    logic scl_f, sda_f, scl_rise, scl_fall;
    logic start_det, rep_start_det, stop_det, bus_busy;

    always #5 clk100 = ~clk100;

    i2c_line_filter dut (
        .clk100       (clk100),
        .reset        (reset),
        .ck_scl       (ck_scl),
        .ck_sda       (ck_sda),
        .scl_f        (scl_f),
        .sda_f        (sda_f),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .rep_start_det(rep_start_det),
        .stop_det     (stop_det),
        .bus_busy     (bus_busy)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pin samples delayed by N edges, then a run-length rule per line.
    bit mq_scl[$];
    bit mq_sda[$];
    bit m_scl, m_sda;
    int run_scl, run_sda;
    bit m_busy, m_armed;
    int m_since;
    bit m_rise, m_fall, m_start, m_rep, m_stop;

    int c_rise, c_fall, c_start, c_rep, c_stop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void line_update(input bit obs, input bit f_in, input int r_in,
                                        output bit f_out, output int r_out);
        f_out = f_in;
        r_out = 0;
        if (obs != f_in) begin
            r_out = r_in + 1;
            if (r_out == F) begin
                f_out = ~f_in;
                r_out = 0;
            end
        end
    endfunction

    task automatic model_edge();
        bit os, od, ps, pd, armed_n;
        if (!reset) begin
            mq_scl = {};
            mq_sda = {};
            repeat (N) begin
                mq_scl.push_back(1'b1);
                mq_sda.push_back(1'b1);
            end
            m_scl = 1; m_sda = 1; run_scl = 0; run_sda = 0;
            m_busy = 0; m_armed = 0; m_since = 0;
            m_rise = 0; m_fall = 0; m_start = 0; m_rep = 0; m_stop = 0;
        end else begin
            os = mq_scl.pop_front();
            od = mq_sda.pop_front();
            mq_scl.push_back(ck_scl);
            mq_sda.push_back(ck_sda);
            armed_n = m_armed || (m_since >= N && os == m_scl && od == m_sda);
            if (m_since < N) m_since++;
            m_busy = m_start ? 1'b1 : (m_stop ? 1'b0 : m_busy);
            ps = m_scl;
            pd = m_sda;
            line_update(os, ps, run_scl, m_scl, run_scl);
            line_update(od, pd, run_sda, m_sda, run_sda);
            m_rise  = !ps && m_scl;
            m_fall  = ps && !m_scl;
            m_start = armed_n && (ps == m_scl) && m_scl && pd && !m_sda;
            m_stop  = armed_n && (ps == m_scl) && m_scl && !pd && m_sda;
            m_rep   = m_start && m_busy;
            m_armed = armed_n;
        end
    endtask

    task automatic step();
        @(posedge clk100);
        model_edge();
        #1;
        chk("scl_f", scl_f, m_scl);
        chk("sda_f", sda_f, m_sda);
        chk("scl_rise", scl_rise, m_rise);
        chk("scl_fall", scl_fall, m_fall);
        chk("start_det", start_det, m_start);
        chk("rep_start_det", rep_start_det, m_rep);
        chk("stop_det", stop_det, m_stop);
        chk("bus_busy", bus_busy, m_busy);
        c_rise  += int'(scl_rise);
        c_fall  += int'(scl_fall);
        c_start += int'(start_det);
        c_rep   += int'(rep_start_det);
        c_stop  += int'(stop_det);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic clr();
        c_rise = 0; c_fall = 0; c_start = 0; c_rep = 0; c_stop = 0;
    endtask

    // Edges are counted from the first sampling edge, so a change shows after LAT+1 steps.
    task automatic wait_line(input bit is_sda, input bit val, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((is_sda ? sda_f : scl_f) !== val) && n < 40);
    endtask

    task automatic scl_clock(input bit bit_val);
        ck_scl = 1'b0; hold(8);
        ck_sda = bit_val; hold(8);
        ck_scl = 1'b1; hold(10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int left_scl, left_sda;
        clr();

        // Reset state
        reset = 1'b0;
        step();
        step();
        chk("rst_scl_f", scl_f, 1);
        chk("rst_sda_f", sda_f, 1);
        chk("rst_busy", bus_busy, 0);
        reset = 1'b1;
        hold(10);

        // START from idle: latency, single pulse, busy next cycle
        clr();
        ck_sda = 1'b0;
        wait_line(1'b1, 1'b0, n);
        chk("start_latency", n, LAT + 1);
        chk("start_pulse", start_det, 1);
        chk("start_busy_lag", bus_busy, 0);
        step();
        chk("busy_after_start", bus_busy, 1);
        chk("start_one_cycle", start_det, 0);
        ck_sda = 1'b1;
        wait_line(1'b1, 1'b1, n);
        chk("stop_pulse", stop_det, 1);
        step();
        chk("busy_after_stop", bus_busy, 0);
        hold(4);

        // Short SCL glitch while idle
        clr();
        ck_scl = 1'b0; hold(F - 1);
        ck_scl = 1'b1; hold(12);
        chk("glitch_scl_f", scl_f, 1);
        chk("glitch_falls", c_fall, 0);
        chk("glitch_starts", c_start, 0);

        // START, 9 clocks, STOP
        clr();
        ck_sda = 1'b0; hold(10);
        for (int i = 0; i < 9; i++) scl_clock(i == 8 ? 1'b0 : 1'($urandom));
        ck_sda = 1'b1; hold(10);
        chk("byte_rises", c_rise, 9);
        chk("byte_falls", c_fall, 9);
        chk("byte_starts", c_start, 1);
        chk("byte_stops", c_stop, 1);
        chk("byte_reps", c_rep, 0);
        chk("byte_busy_end", bus_busy, 0);

        // Repeated START while busy
        ck_sda = 1'b0; hold(10);
        clr();
        scl_clock(1'b1);
        ck_sda = 1'b0; hold(10);
        chk("rep_starts", c_start, 1);
        chk("rep_reps", c_rep, 1);
        chk("rep_busy", bus_busy, 1);
        scl_clock(1'b0);
        ck_sda = 1'b1; hold(10);
        chk("rep_close_stops", c_stop, 1);
        chk("rep_close_busy", bus_busy, 0);

        // Both lines toggled on the same edge
        clr();
        ck_scl = 1'b0; ck_sda = 1'b0; hold(12);
        ck_scl = 1'b1; ck_sda = 1'b1; hold(12);
        chk("same_edge_falls", c_fall, 1);
        chk("same_edge_rises", c_rise, 1);
        chk("same_edge_starts", c_start, 0);
        chk("same_edge_stops", c_stop, 0);

        // Reset pulse mid-transaction with SDA held low
        ck_sda = 1'b0; hold(10);
        ck_scl = 1'b0; hold(8);
        ck_scl = 1'b1; hold(3);
        reset = 1'b0;
        step();
        chk("midrst_sda_f", sda_f, 1);
        chk("midrst_scl_f", scl_f, 1);
        chk("midrst_busy", bus_busy, 0);
        reset = 1'b1;
        clr();
        wait_line(1'b1, 1'b0, n);
        chk("midrst_latency", n, LAT + 1);
        hold(10);
        chk("midrst_starts", c_start, 0);
        // STOP while idle pulses but leaves busy low
        ck_sda = 1'b1; hold(10);
        chk("idle_stop_pulses", c_stop, 1);
        chk("idle_stop_busy", bus_busy, 0);

        // Randomized line activity with occasional reset
        left_scl = 0;
        left_sda = 0;
        for (int i = 0; i < 3000; i++) begin
            if (left_scl == 0) begin
                ck_scl   = ~ck_scl;
                left_scl = int'($urandom_range(1, 12));
            end
            if (left_sda == 0) begin
                ck_sda   = ~ck_sda;
                left_sda = int'($urandom_range(1, 12));
            end
            left_scl--;
            left_sda--;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
